// File: rtl/imem_loader_pkg.sv
// Shared state encoding, sizes and RAM control levels for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int IMEM_WORDS = 2048;
    localparam int LEN_W      = 12;
    localparam int BYTE_W     = 8;
    localparam int LANES      = 4;

    // The RAM2Kx32 controls are all active-low.
    localparam logic RAM_ACTIVE = 1'b0;
    localparam logic RAM_IDLE   = 1'b1;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(IMEM_WORDS)) ? LEN_W'(IMEM_WORDS) : len;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects accepted host bytes into one word; word already includes the byte
// accepted this cycle so the loader can register it on the 4th byte.
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] lanes;

    // Little-endian shifts new bytes in from the top so the first byte ends
    // in bits[7:0]; big-endian shifts in from the bottom.
    assign word = LITTLE_ENDIAN ? {in_byte, lanes[DATA_W-1:BYTE_W]}
                                : {lanes[DATA_W-BYTE_W-1:0], in_byte};

    assign word_valid = accept && (byte_cnt == 2'(LANES - 1));

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (rst) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            lanes    <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Fills the RAM2Kx32 instruction memory from a host byte stream, one word per
// four accepted bytes, starting at BASE_ADDR.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W        = 11,
    parameter int DATA_W        = 32,
    parameter int BASE_ADDR     = 0,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum,
    output logic              im_cen,
    output logic              im_wen,
    output logic              im_oen,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_datain
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic [LEN_W-1:0]  len_latched;
    logic [LEN_W-1:0]  word_idx;
    logic              accept;
    logic              pack_clear;
    logic              word_valid;
    logic [DATA_W-1:0] word;

    // in_ready is only ever high in LOAD, so accept implies LOAD.
    assign accept     = in_valid && in_ready;
    assign pack_clear = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign im_oen     = RAM_IDLE;

    imem_byte_packer #(
        .DATA_W        (DATA_W),
        .LITTLE_ENDIAN (LITTLE_ENDIAN)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .accept     (accept),
        .in_byte    (in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            checksum    <= '0;
            im_cen      <= RAM_IDLE;
            im_wen      <= RAM_IDLE;
            im_addr     <= '0;
            im_datain   <= '0;
            len_latched <= '0;
            word_idx    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        checksum <= '0;
                        if (len == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            len_latched <= clamp_len(len);
                            word_idx    <= '0;
                            done        <= 1'b0;
                            busy        <= 1'b1;
                            in_ready    <= 1'b1;
                            state       <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // Strobes and data are set up here so they are live for
                    // exactly the one WRITE cycle.
                    if (word_valid) begin
                        in_ready  <= 1'b0;
                        im_cen    <= RAM_ACTIVE;
                        im_wen    <= RAM_ACTIVE;
                        im_addr   <= BASE + ADDR_W'(word_idx);
                        im_datain <= word;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    im_cen   <= RAM_IDLE;
                    im_wen   <= RAM_IDLE;
                    checksum <= checksum ^ im_datain;
                    if (word_idx == len_latched - 12'd1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        word_idx <= word_idx + 12'd1;
                        in_ready <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Drives three loaders (little-endian, wrapping base, big-endian) with one
// shared host stream and compares every RAM write against a word-level model.
module tb_imem_loader;

    localparam int NDUT = 3;
    localparam int BASES [NDUT] = '{0, 2047, 0};
    localparam bit LES   [NDUT] = '{1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = '0;

    logic        in_ready_a  [NDUT];
    logic        busy_a      [NDUT];
    logic        done_a      [NDUT];
    logic [31:0] checksum_a  [NDUT];
    logic        im_cen_a    [NDUT];
    logic        im_wen_a    [NDUT];
    logic        im_oen_a    [NDUT];
    logic [10:0] im_addr_a   [NDUT];
    logic [31:0] im_datain_a [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wr_t         exp_q   [NDUT][$];
    logic [31:0] exp_sum [NDUT];
    logic [31:0] tb_ram  [NDUT][2048];
    int          wr_cyc  [NDUT][2048];
    int          acc_tot   [NDUT];
    int          stall_tot [NDUT];
    int          wr_tot    [NDUT];
    logic [7:0]  stim [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem_loader #(
            .ADDR_W        (11),
            .DATA_W        (32),
            .BASE_ADDR     (BASES[g]),
            .LITTLE_ENDIAN (LES[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .len       (len),
            .in_valid  (in_valid),
            .in_byte   (in_byte),
            .in_ready  (in_ready_a[g]),
            .busy      (busy_a[g]),
            .done      (done_a[g]),
            .checksum  (checksum_a[g]),
            .im_cen    (im_cen_a[g]),
            .im_wen    (im_wen_a[g]),
            .im_oen    (im_oen_a[g]),
            .im_addr   (im_addr_a[g]),
            .im_datain (im_datain_a[g])
        );
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: actual=%h required=%h", name, idx, act, req);
        end
    endtask

    // Compare process: every RAM write must be the next word the model expects.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            if (in_valid && in_ready_a[i]) acc_tot[i]++;
            if (busy_a[i] && !in_ready_a[i]) stall_tot[i]++;
            check("oen_high", i, im_oen_a[i], 1);
            check("strobe_pair", i, im_cen_a[i] ^ im_wen_a[i], 0);
            if (im_wen_a[i] === 1'b0) begin
                wr_tot[i]++;
                check("write_expected", i, exp_q[i].size() > 0, 1);
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    check("write_addr", i, im_addr_a[i], e.addr);
                    check("write_data", i, im_datain_a[i], e.data);
                end
                tb_ram[i][im_addr_a[i]] = im_datain_a[i];
                wr_cyc[i][im_addr_a[i]] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [31:0] b);
        for (int k = 3; k >= 0; k--) stim.push_back(b[8*k +: 8]);
    endtask

    task automatic check_reset_values();
        for (int i = 0; i < NDUT; i++) begin
            check("rst_in_ready", i, in_ready_a[i], 0);
            check("rst_busy", i, busy_a[i], 0);
            check("rst_done", i, done_a[i], 0);
            check("rst_checksum", i, checksum_a[i], 0);
            check("rst_cen", i, im_cen_a[i], 1);
            check("rst_wen", i, im_wen_a[i], 1);
            check("rst_oen", i, im_oen_a[i], 1);
            check("rst_addr", i, im_addr_a[i], 0);
            check("rst_datain", i, im_datain_a[i], 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready_a[0] && waited < 8) begin
            tick();
            waited++;
        end
        check("in_ready_wait", 0, in_ready_a[0], 1);
        tick();
    endtask

    // gap_pct==0 keeps in_valid high throughout (host backpressure case).
    task automatic do_load(input int len_in, input int gap_pct, input int busy_start_at, input int abort_after);
        int n;
        int waited;
        int acc0 [NDUT];
        int st0  [NDUT];
        int wr0  [NDUT];
        logic [31:0] w;
        wr_t e;
        n = (len_in > 2048) ? 2048 : len_in;
        while (stim.size() < 4 * n) stim.push_back(8'($urandom));
        for (int i = 0; i < NDUT; i++) begin
            exp_sum[i] = '0;
            for (int k = 0; k < n; k++) begin
                w = LES[i] ? {stim[4*k+3], stim[4*k+2], stim[4*k+1], stim[4*k]}
                           : {stim[4*k], stim[4*k+1], stim[4*k+2], stim[4*k+3]};
                e.addr = 11'((BASES[i] + k) % 2048);
                e.data = w;
                exp_q[i].push_back(e);
                exp_sum[i] ^= w;
            end
            acc0[i] = acc_tot[i];
            st0[i]  = stall_tot[i];
            wr0[i]  = wr_tot[i];
        end
        start = 1'b1;
        len   = 12'(len_in);
        tick();
        start = 1'b0;
        if (n == 0) begin
            for (int i = 0; i < NDUT; i++) begin
                check("empty_done", i, done_a[i], 1);
                check("empty_busy", i, busy_a[i], 0);
                check("empty_in_ready", i, in_ready_a[i], 0);
                check("empty_checksum", i, checksum_a[i], 0);
            end
            repeat (3) tick();
            for (int i = 0; i < NDUT; i++) check("empty_writes", i, wr_tot[i] - wr0[i], 0);
            stim.delete();
            return;
        end
        for (int i = 0; i < NDUT; i++) begin
            check("start_busy", i, busy_a[i], 1);
            check("start_done", i, done_a[i], 0);
        end
        for (int j = 0; j < 4 * n; j++) begin
            if (j == abort_after) begin
                stim.delete();
                return;
            end
            if (j == busy_start_at) begin
                in_valid = 1'b0;
                start    = 1'b1;
                len      = 12'd1;
                tick();
                start    = 1'b0;
            end
            send_byte(stim[j]);
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        if (gap_pct > 0) in_valid = 1'b0;
        waited = 0;
        while (!done_a[0] && waited < 12) begin
            tick();
            waited++;
        end
        repeat (2) tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < NDUT; i++) begin
            check("load_done", i, done_a[i], 1);
            check("load_busy", i, busy_a[i], 0);
            check("load_checksum", i, checksum_a[i], exp_sum[i]);
            check("bytes_consumed", i, acc_tot[i] - acc0[i], 4 * n);
            check("ready_low_cycles", i, stall_tot[i] - st0[i], n);
            check("write_count", i, wr_tot[i] - wr0[i], n);
            check("writes_left", i, exp_q[i].size(), 0);
        end
        stim.delete();
    endtask

    task automatic abort_cleanup();
        for (int i = 0; i < NDUT; i++) exp_q[i].delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int snap;
        int rl;
        #1 rst = 1'b1;
        tick();
        tick();
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        tick();

        do_load(0, 0, -1, -1);

        push_bytes(32'h78563412);
        push_bytes(32'hEFBEADDE);
        do_load(2, 0, -1, -1);
        check("lit_ram0", 0, tb_ram[0][0], 32'h12345678);
        check("lit_ram1", 0, tb_ram[0][1], 32'hDEADBEEF);
        check("lit_checksum", 0, checksum_a[0], 32'hCC99E897);
        check("lit_wrap_2047", 1, tb_ram[1][2047], 32'h12345678);
        check("lit_wrap_0", 1, tb_ram[1][0], 32'hDEADBEEF);
        check("lit_be_ram0", 2, tb_ram[2][0], 32'h78563412);

        push_bytes(32'h12345678);
        do_load(1, 0, 2, -1);
        check("lit_be_word", 2, tb_ram[2][0], 32'h12345678);
        check("lit_le_word", 0, tb_ram[0][0], 32'h78563412);

        for (int r = 0; r < 12; r++) begin
            rl = $urandom_range(1, 24);
            do_load(rl, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(10, 60),
                    ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4 * rl - 1) : -1, -1);
        end

        // Reset while a write strobe is live.
        do_load(2, 0, -1, 4);
        for (int i = 0; i < NDUT; i++) check("wen_before_rst", i, im_wen_a[i], 0);
        rst = 1'b1;
        #1;
        check_reset_values();
        abort_cleanup();

        // Reset after 6 bytes of a 3-word load: word 0 kept, word 1 never written.
        snap = cyc;
        do_load(3, 0, -1, 6);
        rst = 1'b1;
        #1;
        check_reset_values();
        check("abort_ram0_written", 0, wr_cyc[0][0] > snap, 1);
        check("abort_ram1_untouched", 0, wr_cyc[0][1] > snap, 0);
        check("abort_wrap_2047_written", 1, wr_cyc[1][2047] > snap, 1);
        check("abort_wrap_0_untouched", 1, wr_cyc[1][0] > snap, 0);
        abort_cleanup();
        do_load(1, 30, -1, -1);

        do_load(4095, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
